// File: rtl/int_request_arbiter.sv
// Interrupt request arbiter: captures request edges into PEND, masks them, and
// grants one line at a time (fixed priority or round-robin) over valid/ack.
module int_request_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int ID_WIDTH = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfgWrEn_i,
    input  logic [1:0]          cfgAddr_i,
    input  logic [31:0]         cfgWrData_i,
    output logic [31:0]         cfgRdData_o,
    input  logic [NUM_REQ-1:0]  reqIn_i,
    output logic                gntValid_o,
    output logic [ID_WIDTH-1:0] gntId_o,
    input  logic                gntAck_i
);

    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  mask_q;
    logic [NUM_REQ-1:0]  pend_q;
    logic [NUM_REQ-1:0]  pend_d;
    logic [NUM_REQ-1:0]  reqLast_q;
    logic                mode_q;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] gntId_q;
    logic                gntValid_q;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  setVec;
    logic [NUM_REQ-1:0]  clrVec;
    logic                maskWr;
    logic                modeWr;
    logic                pendWr;
    logic                ackTaken;
    logic                lowFound;
    logic                upFound;
    logic [ID_WIDTH-1:0] lowIdx;
    logic [ID_WIDTH-1:0] upIdx;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] nextPtr;

    assign maskWr   = cfgWrEn_i && (cfgAddr_i == 2'd0);
    assign modeWr   = cfgWrEn_i && (cfgAddr_i == 2'd1);
    assign pendWr   = cfgWrEn_i && (cfgAddr_i == 2'd2);
    assign ackTaken = (state_q == GRANT) && gntAck_i;
    assign eligible = pend_q & mask_q;
    assign setVec   = reqIn_i & ~reqLast_q;

    // Descending scan so the last hit is the lowest index; upIdx only counts lines at or above the pointer.
    always_comb begin
        lowFound = 1'b0;
        upFound  = 1'b0;
        lowIdx   = '0;
        upIdx    = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                lowFound = 1'b1;
                lowIdx   = ID_WIDTH'(j);
                if (j >= int'(ptr_q)) begin
                    upFound = 1'b1;
                    upIdx   = ID_WIDTH'(j);
                end
            end
        end
    end

    assign winner  = (mode_q && upFound) ? upIdx : lowIdx;
    assign nextPtr = (gntId_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gntId_q + ID_WIDTH'(1);

    always_comb begin
        clrVec = '0;
        if (pendWr) begin
            clrVec = cfgWrData_i[NUM_REQ-1:0];
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ackTaken && (gntId_q == ID_WIDTH'(j))) begin
                clrVec[j] = 1'b1;
            end
        end
    end

    // New edges override any clear landing in the same cycle.
    assign pend_d = (pend_q & ~clrVec) | setVec;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q    <= '0;
            mode_q    <= 1'b0;
            pend_q    <= '0;
            reqLast_q <= '0;
        end else begin
            pend_q    <= pend_d;
            reqLast_q <= reqIn_i;
            if (maskWr) begin
                mask_q <= cfgWrData_i[NUM_REQ-1:0];
            end
            if (modeWr) begin
                mode_q <= cfgWrData_i[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gntValid_q <= 1'b0;
            gntId_q    <= '0;
            ptr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lowFound) begin
                        gntId_q    <= winner;
                        gntValid_q <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (gntAck_i) begin
                        ptr_q      <= nextPtr;
                        gntValid_q <= 1'b0;
                        state_q    <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cfgRdData_o = '0;
        case (cfgAddr_i)
            2'd0: cfgRdData_o[NUM_REQ-1:0] = mask_q;
            2'd1: cfgRdData_o[0] = mode_q;
            2'd2: cfgRdData_o[NUM_REQ-1:0] = pend_q;
            default: begin
                cfgRdData_o[ID_WIDTH-1:0] = gntId_q;
                cfgRdData_o[8]            = gntValid_q;
                cfgRdData_o[11:9]         = 3'(ptr_q);
            end
        endcase
    end

    assign gntValid_o = gntValid_q;
    assign gntId_o    = gntId_q;

endmodule

// File: tb/tb_int_request_arbiter.sv
// Self-checking bench for int_request_arbiter: a cycle-level behavioural model
// is compared every cycle, plus directed scenarios with hand-computed results.
module tb_int_request_arbiter;

    localparam int N = 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wrEn   = 1'b0;
    logic [1:0]  addr   = 2'd0;
    logic [31:0] wrData = 32'd0;
    logic [7:0]  req    = 8'd0;
    logic        ack    = 1'b0;
    logic [31:0] rdData;
    logic        gntValid;
    logic [2:0]  gntId;

    int checks     = 0;
    int failures   = 0;
    int cycleCount = 0;

    int_request_arbiter #(.NUM_REQ(8), .ID_WIDTH(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfgWrEn_i   (wrEn),
        .cfgAddr_i   (addr),
        .cfgWrData_i (wrData),
        .cfgRdData_o (rdData),
        .reqIn_i     (req),
        .gntValid_o  (gntValid),
        .gntId_o     (gntId),
        .gntAck_i    (ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural model: pending set, mask, mode, pointer and an in-flight grant with a one-cycle cooldown.
    logic [7:0] mPend  = 8'd0;
    logic [7:0] mLast  = 8'd0;
    logic [7:0] mMask  = 8'd0;
    logic       mMode  = 1'b0;
    logic       mValid = 1'b0;
    logic       mHold  = 1'b0;
    int         mPtr   = 0;
    int         mId    = 0;

    logic [7:0] tSet;
    logic [7:0] tClr;
    logic [7:0] tElig;
    logic       tValid;
    logic       tHold;
    int         tPtr;
    int         tId;
    int         tWin;
    int         tCand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPend  <= 8'd0;
            mLast  <= 8'd0;
            mMask  <= 8'd0;
            mMode  <= 1'b0;
            mValid <= 1'b0;
            mHold  <= 1'b0;
            mPtr   <= 0;
            mId    <= 0;
        end else begin
            tSet   = req & ~mLast;
            tClr   = (wrEn && addr == 2'd2) ? wrData[7:0] : 8'd0;
            tValid = mValid;
            tHold  = 1'b0;
            tPtr   = mPtr;
            tId    = mId;
            if (mValid) begin
                if (ack) begin
                    tClr   = tClr | (8'd1 << mId);
                    tPtr   = (mId + 1) % N;
                    tValid = 1'b0;
                    tHold  = 1'b1;
                end
            end else if (!mHold) begin
                tElig = mPend & mMask;
                tWin  = -1;
                for (int k = 0; k < N; k++) begin
                    tCand = mMode ? (mPtr + k) % N : k;
                    if (tWin < 0 && ((tElig >> tCand) & 8'd1) != 8'd0) tWin = tCand;
                end
                if (tWin >= 0) begin
                    tValid = 1'b1;
                    tId    = tWin;
                end
            end
            mPend  <= (mPend & ~tClr) | tSet;
            mLast  <= req;
            if (wrEn && addr == 2'd0) mMask <= wrData[7:0];
            if (wrEn && addr == 2'd1) mMode <= wrData[0];
            mValid <= tValid;
            mHold  <= tHold;
            mPtr   <= tPtr;
            mId    <= tId;
        end
    end

    function automatic logic [31:0] expRd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, mMask};
            2'd1:    return {31'd0, mMode};
            2'd2:    return {24'd0, mPend};
            default: return (32'(mPtr) << 9) | (32'(mValid) << 8) | 32'(mId);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.gntValid", {31'd0, gntValid}, {31'd0, mValid});
        checkOutput("model.gntId", {29'd0, gntId}, 32'(mId));
        checkOutput("model.cfgRdData", rdData, expRd(addr));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] lines);
        req = lines;
        tick();
        req = 8'd0;
    endtask

    task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
        addr   = a;
        wrData = d;
        wrEn   = 1'b1;
        tick();
        wrEn   = 1'b0;
        wrData = 32'd0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdData;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        req   = 8'd0;
        ack   = 1'b0;
        wrEn  = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic waitGrant(input int maxCyc, output int cyc);
        int n;
        n = 0;
        while (!gntValid && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput("grantArrives", {31'd0, gntValid}, 32'd1);
        cyc = cycleCount;
    endtask

    task automatic ackNow();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    logic [31:0] v;
    int t1, t2, tW, tAck;
    int rrIds[5]  = '{1, 3, 6, 1, 6};
    int rrPtrs[5] = '{2, 4, 7, 2, 7};

    initial begin
        tick(2);
        checkOutput("reset.gntValid", {31'd0, gntValid}, 32'd0);
        readReg(2'd0, v);
        checkOutput("reset.mask", v, 32'd0);
        readReg(2'd3, v);
        checkOutput("reset.stat", v, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Fixed priority: lines 5 and 2 together.
        cfgWrite(2'd0, 32'hFF);
        applyStimulus(8'h24);
        waitGrant(10, t1);
        checkOutput("fixed.first", {29'd0, gntId}, 32'd2);
        ackNow();
        waitGrant(10, t2);
        checkOutput("fixed.second", {29'd0, gntId}, 32'd5);
        checkOutput("fixed.spacing", 32'(t2 - t1), 32'd3);
        ackNow();
        tick();
        readReg(2'd2, v);
        checkOutput("fixed.pendEmpty", v, 32'd0);

        // Round-robin from pointer 0, then wrap from pointer 7.
        applyReset();
        cfgWrite(2'd0, 32'hFF);
        cfgWrite(2'd1, 32'h1);
        applyStimulus(8'h4A);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) applyStimulus(8'h42);
            waitGrant(10, t1);
            checkOutput("rr.id", {29'd0, gntId}, 32'(rrIds[i]));
            ackNow();
            readReg(2'd3, v);
            checkOutput("rr.ptr", {29'd0, v[11:9]}, 32'(rrPtrs[i]));
        end

        // Masked line captures but does not grant until enabled.
        applyReset();
        applyStimulus(8'h10);
        readReg(2'd2, v);
        checkOutput("mask.pend", v, 32'h10);
        tick(3);
        checkOutput("mask.noGrant", {31'd0, gntValid}, 32'd0);
        tW = cycleCount;
        cfgWrite(2'd0, 32'h10);
        checkOutput("mask.notYet", {31'd0, gntValid}, 32'd0);
        waitGrant(10, t1);
        checkOutput("mask.latency", 32'(t1 - tW), 32'd2);
        checkOutput("mask.id", {29'd0, gntId}, 32'd4);
        ackNow();

        // Ack, new edge and W1C on line 3 in the same cycle.
        cfgWrite(2'd0, 32'hFF);
        applyStimulus(8'h08);
        waitGrant(10, t1);
        checkOutput("simul.id", {29'd0, gntId}, 32'd3);
        tAck   = cycleCount;
        ack    = 1'b1;
        req    = 8'h08;
        addr   = 2'd2;
        wrData = 32'h08;
        wrEn   = 1'b1;
        tick();
        ack    = 1'b0;
        req    = 8'd0;
        wrEn   = 1'b0;
        wrData = 32'd0;
        readReg(2'd2, v);
        checkOutput("simul.pend3", {31'd0, v[3]}, 32'd1);
        waitGrant(10, t2);
        checkOutput("simul.regrantDelay", 32'(t2 - tAck), 32'd3);
        checkOutput("simul.regrantId", {29'd0, gntId}, 32'd3);
        ackNow();

        // Grant holds through mask clear and W1C of its own line.
        applyStimulus(8'h40);
        waitGrant(10, t1);
        for (int i = 0; i < 20; i++) begin
            wrEn   = (i == 2) || (i == 5);
            addr   = (i == 5) ? 2'd2 : 2'd0;
            wrData = (i == 2) ? 32'hBF : 32'h40;
            tick();
            wrEn = 1'b0;
            checkOutput("hold.valid", {31'd0, gntValid}, 32'd1);
            checkOutput("hold.id", {29'd0, gntId}, 32'd6);
        end
        readReg(2'd0, v);
        checkOutput("hold.mask", v, 32'hBF);
        ackNow();
        checkOutput("hold.released", {31'd0, gntValid}, 32'd0);
        tick(3);
        checkOutput("hold.noRegrant", {31'd0, gntValid}, 32'd0);

        // Asynchronous reset while a grant is outstanding.
        cfgWrite(2'd0, 32'hFF);
        applyStimulus(8'h04);
        waitGrant(10, t1);
        checkOutput("rst.preId", {29'd0, gntId}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst.validDrop", {31'd0, gntValid}, 32'd0);
        addr = 2'd0;
        #1;
        checkOutput("rst.mask", rdData, 32'd0);
        addr = 2'd2;
        #1;
        checkOutput("rst.pend", rdData, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rst.idle", {31'd0, gntValid}, 32'd0);
        end
        applyStimulus(8'h04);
        tick(3);
        checkOutput("rst.maskedEdge", {31'd0, gntValid}, 32'd0);
        cfgWrite(2'd0, 32'h04);
        waitGrant(10, t1);
        checkOutput("rst.newGrant", {29'd0, gntId}, 32'd2);
        ackNow();
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_request_arbiter.md
# int_request_arbiter

Programmable arbiter that captures edge-triggered interrupt requests from peripherals, applies a per-line enable mask, and selects one pending line at a time. Selection uses either fixed priority or round-robin. The selected line is presented to the downstream interrupt controller over a valid/ack handshake. Software configures and inspects the block through a small register port on the same clock domain.

## Interface
Parameters:
- NUM_REQ, 8: number of request lines, 2..8.
- ID_WIDTH, 3: width of the grant ID; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- Clock  in  1  block clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CfgWrEn  in  1  register write strobe, one cycle per write.
- CfgAddr  in  2  register select: 0 MASK, 1 MODE, 2 PEND, 3 STAT.
- CfgWrData  in  32  write data.
- CfgRdData  out  32  combinational read of the register at CfgAddr; unused bits read 0.
- ReqIn  in  NUM_REQ  level requests, already synchronous to Clock.
- GntValid  out  1  a grant is being presented.
- GntId  out  ID_WIDTH  index of the granted line; stable while GntValid=1.
- GntAck  in  1  consumer accepts the grant.

## Operation
- Registers:
  - MASK[NUM_REQ-1:0] is R/W; 1 = line enabled.
  - MODE[0] is R/W; 0 = fixed priority, lowest index wins; 1 = round-robin.
  - PEND[NUM_REQ-1:0] is read; a write of 1 clears the corresponding bit.
  - STAT is read-only: [ID_WIDTH-1:0] = last GntId, [8] = GntValid, [11:9] = RR pointer.
- Edge capture:
  - ReqLast registers ReqIn every cycle.
  - PEND[i] is set when ReqIn[i] & ~ReqLast[i].
  - A set in the same cycle as any clear (ack clear or W1C) wins.
  - PEND captures edges even when the line is masked.
- Eligible vector: E = PEND & MASK.
- Winner selection:
  - Fixed priority: the lowest set bit of E.
  - Round-robin: the first set bit of E scanning upward from pointer P, wrapping at NUM_REQ-1 back to 0.
- State machine (IDLE, GRANT, HOLDOFF):
  - IDLE: if E != 0, register GntId <= winner and GntValid <= 1, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold GntValid and GntId. On the cycle GntAck=1:
    - clear PEND[GntId] (a simultaneous new edge on that line keeps it set);
    - P <= (GntId+1) mod NUM_REQ;
    - GntValid <= 0;
    - go to HOLDOFF.
  - HOLDOFF: one cycle, then go to IDLE.
- Disturbances during GRANT:
  - Clearing the MASK bit or W1C of the granted PEND bit does not withdraw the grant; the ack still completes normally.
  - MODE or MASK changes take effect at the next IDLE evaluation.
- GntAck sampled in IDLE or HOLDOFF is ignored.
- CfgWrEn writes to STAT are ignored.
- Reset mid-grant: everything returns to reset values immediately (asynchronous), and the pending grant is lost.
- Reset values: GntValid=0, GntId=0, PEND=0, ReqLast=0, MASK=0, MODE=0, P=0, state IDLE, CfgRdData = register contents (all zero).

## Timing
- A rising edge of ReqIn[i] first seen in cycle n sets PEND[i] at the end of cycle n.
- If the line is enabled and the FSM is idle, GntValid=1 from cycle n+2.
- An ack sampled in cycle k gives GntValid=0 in cycle k+1 (HOLDOFF) and IDLE in k+2. The next GntValid is no earlier than k+3.
- Minimum grant spacing is therefore 3 cycles (back-to-back requests with ack tied high).
- A register write in cycle w is visible on CfgRdData in cycle w+1 and affects arbitration from cycle w+1.
- No combinational path from GntAck to GntValid or GntId.

## Test plan
- Fixed priority: MASK=0xFF, MODE=0, pulse ReqIn[5] and ReqIn[2] in the same cycle, ack each grant one cycle after GntValid rises. Required: GntId=2 then GntId=5, grants 3 cycles apart, PEND=0x00 at the end.
- Round-robin: MODE=1, lines 1, 3 and 6 pending. Required grant order 1,3,6 with STAT pointer 2,4,7. Then re-raise lines 1 and 6 with P=7. Required order 1 then 6 (wrap-around).
- Masking: MASK=0x00, pulse ReqIn[4]. Required: PEND=0x10 and no grant. Write MASK=0x10. Required: GntValid rises 2 cycles after the write cycle, with GntId=4.
- Simultaneous events: in the ack cycle for line 3, also raise a new ReqIn[3] edge and W1C PEND[3]. Required: PEND[3]=1 afterwards, and line 3 is granted again 3 cycles after the ack.
- Grant stability: hold GntAck=0 for 20 cycles while clearing MASK[GntId] and W1C-ing its PEND bit. Required: GntValid and GntId stay constant until the ack, then the handshake completes normally.
- Reset in GRANT state: assert Reset asynchronously mid-cycle. Required: GntValid=0 immediately, PEND=0, MASK=0, and after release no grant until a new edge arrives and MASK is enabled.
